// File: rtl/course1_pkg.sv
// course1_pkg: shared widths, LED bit positions and the heartbeat width
// default for the switch-to-LED introductory block.
package course1_pkg;

  localparam int SW_W  = 4;
  localparam int LED_W = 16;

  localparam int LED_PARITY  = 0;
  localparam int LED_AND     = 1;
  localparam int LED_OR      = 2;
  localparam int LED_MAJ     = 3;
  localparam int LED_ECHO_LO = 4;
  localparam int LED_CNT_LO  = 8;
  localparam int LED_NBCD    = 11;
  localparam int LED_HB      = 15;

  localparam int HB_WIDTH_DEFAULT = 24;

endpackage

// File: rtl/course1_if.sv
// course1_if: bundles the slide-switch inputs and the LED outputs.
// The master side drives the switches; the slave side is the course1 block.
interface course1_if;
  import course1_pkg::*;

  logic [SW_W-1:0]  SW;
  logic [LED_W-1:0] LED;

  modport master (output SW, input LED);
  modport slave  (input SW, output LED);

endinterface

// File: rtl/course1_sync.sv
// course1_sync: generic N-bit two-stage synchronizer with asynchronous
// active-high reset. Both stages clear while rst is high.
module course1_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  // Two flops in series give the first stage a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/course1.sv
// course1: samples the slide switches, decodes parity/AND/OR/majority,
// echo, population count and a non-BCD flag into registered LEDs, and
// drives LED[15] from a free-running heartbeat counter.
// Build option: define COURSE1_SYNC_EN to pass SW through a 2-flop
// synchronizer (3-cycle latency); otherwise SW is registered directly
// (1-cycle latency) and must already be synchronous to clk.
module course1
  import course1_pkg::*;
#(
  parameter int HB_WIDTH = HB_WIDTH_DEFAULT
) (
  input logic      clk,
  input logic      rst,
  course1_if.slave io
);

  logic [SW_W-1:0]     s;
  logic [11:0]         dec;
  logic [11:0]         dec_q;
  logic [2:0]          cnt;
  logic [HB_WIDTH-1:0] hb;

`ifdef COURSE1_SYNC_EN
  course1_sync #(.N(SW_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io.SW),
    .q   (s)
  );
`else
  assign s = io.SW;
`endif

  // All decoded functions derive from one sample of s so they always agree.
  always_comb begin
    dec = '0;
    cnt = 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
    dec[LED_PARITY]             = ^s;
    dec[LED_AND]                = &s;
    dec[LED_OR]                 = |s;
    dec[LED_MAJ]                = (cnt >= 3'd3);
    dec[LED_ECHO_LO +: SW_W]    = s;
    dec[LED_CNT_LO +: 3]        = cnt;
    dec[LED_NBCD]               = (s >= 4'd10);
  end

  // Output register: every decoded LED updates together on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec;
    end
  end

  // Heartbeat counter free-runs and wraps; its MSB blinks LED[15].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb <= '0;
    end else begin
      hb <= hb + HB_WIDTH'(1);
    end
  end

  assign io.LED = {hb[HB_WIDTH-1], 3'b000, dec_q};

endmodule

// File: tb/tb_course1.sv
// tb_course1: table-driven check of the course1 switch decoder, plus
// hand-written sequences for reset, heartbeat and per-cycle switch changes.
// Honours COURSE1_SYNC_EN to pick the expected latency.
module tb_course1;
  import course1_pkg::*;

`ifdef COURSE1_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [3:0]  sw;
    logic [11:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[16];
  logic [3:0] hist[$];

  course1_if bus();

  course1 #(.HB_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] s);
    bus.SW = s;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] prev;
    logic [3:0]  s;

    // Hand-computed {nbcd, cnt[2:0], echo[3:0], maj, or, and, parity}.
    vecs[0]  = '{4'h0, 12'h000};
    vecs[1]  = '{4'h1, 12'h115};
    vecs[2]  = '{4'h2, 12'h125};
    vecs[3]  = '{4'h3, 12'h234};
    vecs[4]  = '{4'h4, 12'h145};
    vecs[5]  = '{4'h5, 12'h254};
    vecs[6]  = '{4'h6, 12'h264};
    vecs[7]  = '{4'h7, 12'h37D};
    vecs[8]  = '{4'h8, 12'h185};
    vecs[9]  = '{4'h9, 12'h294};
    vecs[10] = '{4'hA, 12'hAA4};
    vecs[11] = '{4'hB, 12'hBBD};
    vecs[12] = '{4'hC, 12'hAC4};
    vecs[13] = '{4'hD, 12'hBDD};
    vecs[14] = '{4'hE, 12'hBED};
    vecs[15] = '{4'hF, 12'hCFE};

    // Reset held with all switches on: LEDs stay dark.
    rst = 1'b1;
    applyStimulus(4'hF);
    #1;
    checkOutput("reset_hold_t0", bus.LED, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("reset_hold", bus.LED, 16'h0000);
    end

    // Release reset; pipeline must start empty, then show SW=F.
    rst = 1'b0;
    checkOutput("post_reset_empty", {1'b0, bus.LED[14:0]}, 16'h0000);
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      checkOutput("post_reset_pending", {1'b0, bus.LED[14:0]}, 16'h0000);
    end
    tick();
    checkOutput("post_reset_first", {1'b0, bus.LED[14:0]}, {4'h0, vecs[15].exp});

    // Mid-cycle reset clears immediately, before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_clear", bus.LED, 16'h0000);

    // Heartbeat with HB_WIDTH=4: low for 8 edges, high for 8, repeating.
    tick();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      checkOutput("heartbeat", {12'h000, bus.LED[15:12]},
                  {12'h000, ((k % 16) >= 8) ? 1'b1 : 1'b0, 3'b000});
    end

    // Sweep all switch values; verify exact latency and held value.
    applyStimulus(4'h0);
    doReset();
    prev = 12'h000;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].sw);
      for (int j = 0; j <= 10; j++) begin
        if (j > 0) tick();
        if (j == LAT - 1)
          checkOutput("sweep_before_latency", {1'b0, bus.LED[14:0]}, {4'h0, prev});
        if (j == LAT)
          checkOutput("sweep_at_latency", {1'b0, bus.LED[14:0]}, {4'h0, vecs[i].exp});
        if (j == 10)
          checkOutput("sweep_hold", {1'b0, bus.LED[14:0]}, {4'h0, vecs[i].exp});
      end
      prev = vecs[i].exp;
    end

    // Switches change every cycle: each snapshot matches one earlier sample.
    for (int i = 0; i < LAT - 1; i++) hist.push_back(4'hF);
    for (int c = 0; c < 24; c++) begin
      s = 4'($urandom_range(0, 15));
      applyStimulus(s);
      hist.push_back(s);
      tick();
      checkOutput("glitch", {1'b0, bus.LED[14:0]},
                  {4'h0, vecs[hist[hist.size() - LAT]].exp});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
